vdp_cpu_port: RTL and testbench

//  CPU-side controller for the VDP at IO 0x80 (data, a[0]=0) / 0x81 (ctrl, a[0]=1): TMS9918-style
//  two-byte control protocol, 8 control regs, 14-bit auto-increment VRAM pointer, read-ahead buffer.

---
 rtl/vdp_pkg.sv | 31 +++
 rtl/vdp_vram_arb.sv | 74 +++++++
 rtl/vdp_cpu_port.sv | 176 +++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: control codes, pending-op encoding
// and status-register bit layout.
package vdp_pkg;

    localparam logic       PORT_DATA  = 1'b0;
    localparam logic       PORT_CTRL  = 1'b1;

    localparam logic [1:0] CTRL_REG   = 2'b10;
    localparam logic [1:0] CTRL_WADDR = 2'b01;
    localparam logic [1:0] CTRL_RADDR = 2'b00;

    typedef enum logic [1:0] {
        OP_NONE     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_PREFETCH = 2'd2
    } pend_op_e;

    localparam int ST_F   = 7;
    localparam int ST_C5  = 6;
    localparam int ST_OVR = 5;

    function automatic logic [7:0] status_byte(input logic f, input logic c5, input logic ovr);
        logic [7:0] s;
        s         = 8'h00;
        s[ST_F]   = f;
        s[ST_C5]  = c5;
        s[ST_OVR] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/vdp_vram_arb.sv
// Single-slot CPU VRAM op holder and arbiter against the video fetch engine;
// video wins until the CPU op has waited STARVE cycles.
module vdp_vram_arb
    import vdp_pkg::*;
#(
    parameter int AW     = 14,
    parameter int STARVE = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  pend_op_e      load_op_i,
    input  logic [7:0]    load_data_i,
    input  logic [AW-1:0] ptr_i,
    input  logic          vid_req_i,
    input  logic [AW-1:0] vid_addr_i,
    output logic          cpu_run_o,
    output logic          run_prefetch_o,
    output logic          busy_o,
    output logic          vid_gnt_o,
    output logic [AW-1:0] vram_addr_o,
    output logic [7:0]    vram_wdata_o,
    output logic          vram_we_o
);

    localparam int CW = $clog2(STARVE + 1);

    pend_op_e      op_q, op_d;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_s;

    // Grant decision and slot/wait-counter next state; a new load replaces any older op.
    always_comb begin
        op_d   = op_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        run_s  = !reset && (op_q != OP_NONE) && (!vid_req_i || (cnt_q == CW'(STARVE)));
        if (load_i) begin
            op_d   = load_op_i;
            data_d = load_data_i;
            cnt_d  = '0;
        end else if (run_s) begin
            op_d   = OP_NONE;
            cnt_d  = '0;
        end else if ((op_q != OP_NONE) && vid_req_i) begin
            cnt_d  = cnt_q + CW'(1);
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Slot and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= OP_NONE;
            data_q <= 8'h00;
            cnt_q  <= '0;
        end else begin
            op_q   <= op_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cpu_run_o      = run_s;
    assign run_prefetch_o = run_s && (op_q == OP_PREFETCH);
    assign busy_o         = (op_q != OP_NONE);
    assign vid_gnt_o      = vid_req_i && !run_s;
    assign vram_addr_o    = run_s ? ptr_i : vid_addr_i;
    assign vram_wdata_o   = data_q;
    assign vram_we_o      = run_s && (op_q == OP_WRITE);

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side VDP port: two-byte control protocol, register file, auto-increment
// VRAM pointer, read-ahead buffer and status/interrupt flags.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int AW     = 14,
    parameter int STARVE = 8
) (
    input  logic          pxclk,
    input  logic          reset,
    input  logic          cpu_wr_tick,
    input  logic          cpu_rd_tick,
    input  logic          cpu_mode,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_busy,
    input  logic          vsync_tick,
    output logic          int_n,
    output logic [63:0]   regs,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic [7:0]    vid_rdata,
    output logic [AW-1:0] vram_addr,
    output logic [7:0]    vram_wdata,
    output logic          vram_we,
    input  logic [7:0]    vram_rdata
);

    logic [63:0]   regs_q, regs_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          toggle_q, toggle_d;
    logic [7:0]    latch_q, latch_d;
    logic          f_q, f_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    rdbuf_q, rdbuf_d;
    logic [7:0]    dout_q, dout_d;
    logic          pf_q;

    logic          data_wr_s, data_rd_s, ctrl_wr_s, stat_rd_s, ctrl2_s;
    logic          busy_s, drop_s, load_s, cpu_run_s, run_pf_s;
    pend_op_e      load_op_s;

    assign data_wr_s = cpu_wr_tick && (cpu_mode == PORT_DATA);
    assign data_rd_s = cpu_rd_tick && (cpu_mode == PORT_DATA);
    assign ctrl_wr_s = cpu_wr_tick && (cpu_mode == PORT_CTRL);
    assign stat_rd_s = cpu_rd_tick && (cpu_mode == PORT_CTRL);
    assign ctrl2_s   = ctrl_wr_s && toggle_q;
    assign drop_s    = (data_wr_s || data_rd_s) && busy_s;

    // Which CPU action, if any, places a new op in the arbiter slot this cycle.
    always_comb begin
        load_s    = 1'b0;
        load_op_s = OP_NONE;
        if (ctrl2_s && (cpu_din[7:6] == CTRL_RADDR)) begin
            load_s    = 1'b1;
            load_op_s = OP_PREFETCH;
        end else if (data_wr_s && !busy_s) begin
            load_s    = 1'b1;
            load_op_s = OP_WRITE;
        end else if (data_rd_s && !busy_s) begin
            load_s    = 1'b1;
            load_op_s = OP_PREFETCH;
        end else begin
            load_s    = 1'b0;
            load_op_s = OP_NONE;
        end
    end

    vdp_vram_arb #(.AW(AW), .STARVE(STARVE)) u_arb (
        .clk            (pxclk),
        .reset          (reset),
        .load_i         (load_s),
        .load_op_i      (load_op_s),
        .load_data_i    (cpu_din),
        .ptr_i          (ptr_q),
        .vid_req_i      (vid_req),
        .vid_addr_i     (vid_addr),
        .cpu_run_o      (cpu_run_s),
        .run_prefetch_o (run_pf_s),
        .busy_o         (busy_s),
        .vid_gnt_o      (vid_gnt),
        .vram_addr_o    (vram_addr),
        .vram_wdata_o   (vram_wdata),
        .vram_we_o      (vram_we)
    );

    // Protocol next state; a prefetch landing this cycle is forwarded straight to a data read.
    always_comb begin
        regs_d   = regs_q;
        ptr_d    = ptr_q;
        toggle_d = toggle_q;
        latch_d  = latch_q;
        rdbuf_d  = rdbuf_q;
        dout_d   = dout_q;

        if (ctrl_wr_s) begin
            toggle_d = !toggle_q;
        end else if (cpu_rd_tick || data_wr_s) begin
            toggle_d = 1'b0;
        end else begin
            toggle_d = toggle_q;
        end

        if (ctrl_wr_s && !toggle_q) begin
            latch_d = cpu_din;
        end else begin
            latch_d = latch_q;
        end

        if (ctrl2_s && (cpu_din[7] == CTRL_REG[1])) begin
            regs_d[{cpu_din[2:0], 3'b000} +: 8] = latch_q;
        end else begin
            regs_d = regs_q;
        end

        if (ctrl2_s && (cpu_din[7] != CTRL_REG[1])) begin
            ptr_d = AW'({cpu_din[5:0], latch_q});
        end else if (cpu_run_s) begin
            ptr_d = ptr_q + AW'(1);
        end else begin
            ptr_d = ptr_q;
        end

        if (data_wr_s && !busy_s) begin
            rdbuf_d = cpu_din;
        end else if (pf_q) begin
            rdbuf_d = vram_rdata;
        end else begin
            rdbuf_d = rdbuf_q;
        end

        if (data_rd_s) begin
            dout_d = pf_q ? vram_rdata : rdbuf_q;
        end else if (stat_rd_s) begin
            dout_d = status_byte(f_q, 1'b0, ovr_q);
        end else begin
            dout_d = dout_q;
        end

        f_d   = vsync_tick ? 1'b1 : (stat_rd_s ? 1'b0 : f_q);
        ovr_d = drop_s     ? 1'b1 : (stat_rd_s ? 1'b0 : ovr_q);
    end

    // Protocol and status registers.
    always_ff @(posedge pxclk) begin
        if (reset) begin
            regs_q   <= 64'h0;
            ptr_q    <= '0;
            toggle_q <= 1'b0;
            latch_q  <= 8'h00;
            f_q      <= 1'b0;
            ovr_q    <= 1'b0;
            rdbuf_q  <= 8'h00;
            dout_q   <= 8'h00;
            pf_q     <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            ptr_q    <= ptr_d;
            toggle_q <= toggle_d;
            latch_q  <= latch_d;
            f_q      <= f_d;
            ovr_q    <= ovr_d;
            rdbuf_q  <= rdbuf_d;
            dout_q   <= dout_d;
            pf_q     <= run_pf_s;
        end
    end

    assign cpu_dout  = dout_q;
    assign cpu_busy  = busy_s;
    assign int_n     = !(f_q && regs_q[8 + 5]);
    assign regs      = regs_q;
    assign vid_rdata = vram_rdata;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port with a behavioural 1-cycle-latency VRAM.
module tb_vdp_cpu_port;

    localparam int AW     = 14;
    localparam int STARVE = 8;

    logic          pxclk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_wr_tick = 1'b0, cpu_rd_tick = 1'b0, cpu_mode = 1'b0;
    logic [7:0]    cpu_din = 8'h00;
    logic [7:0]    cpu_dout;
    logic          cpu_busy, int_n, vid_gnt, vram_we;
    logic          vsync_tick = 1'b0, vid_req = 1'b0;
    logic [63:0]   regs;
    logic [AW-1:0] vid_addr = '0, vram_addr;
    logic [7:0]    vid_rdata, vram_wdata, vram_rdata;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW+7:0] wr_q [$];
    logic [7:0]    rd_q [$];
    int            n_checks = 0;
    int            n_errors = 0;

    vdp_cpu_port #(.AW(AW), .STARVE(STARVE)) dut (
        .pxclk(pxclk), .reset(reset), .cpu_wr_tick(cpu_wr_tick), .cpu_rd_tick(cpu_rd_tick),
        .cpu_mode(cpu_mode), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
        .vsync_tick(vsync_tick), .int_n(int_n), .regs(regs), .vid_req(vid_req),
        .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rdata(vid_rdata), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata)
    );

    always #20 pxclk = ~pxclk;

    always @(posedge pxclk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every VRAM write must match the oldest expected write.
    always @(negedge pxclk) begin : wr_mon
        logic [AW+7:0] e;
        if (vram_we) begin
            e = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
            check_eq("vram_wr", 32'({vram_addr, vram_wdata}), 32'(e));
        end
    end

    task automatic tick_wr(input logic mode, input logic [7:0] d);
        cpu_mode    = mode;
        cpu_din     = d;
        cpu_wr_tick = 1'b1;
        @(posedge pxclk); #1;
        cpu_wr_tick = 1'b0;
    endtask

    task automatic ctrl(input logic [7:0] b0, input logic [7:0] b1);
        tick_wr(1'b1, b0);
        tick_wr(1'b1, b1);
    endtask

    task automatic data_wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        tick_wr(1'b0, d);
    endtask

    task automatic rd(input logic mode, input logic [7:0] exp, input string tag);
        rd_q.push_back(exp);
        cpu_mode    = mode;
        cpu_rd_tick = 1'b1;
        @(posedge pxclk); #1;
        cpu_rd_tick = 1'b0;
        @(negedge pxclk);
        check_eq(tag, 32'(cpu_dout), 32'(rd_q.pop_front()));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cpu_busy && n < 64) begin
            @(negedge pxclk);
            n++;
        end
        if (n >= 64) check_eq("busy_timeout", 32'(cpu_busy), 32'd0);
        repeat (2) @(posedge pxclk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge pxclk);
        #1 reset = 1'b0;
        @(negedge pxclk);
        check_eq("rst_regs_lo", regs[31:0], 32'd0);
        check_eq("rst_regs_hi", regs[63:32], 32'd0);
        check_eq("rst_dout", 32'(cpu_dout), 32'd0);
        check_eq("rst_int_n", 32'(int_n), 32'd1);
        check_eq("rst_busy", 32'(cpu_busy), 32'd0);

        // Register write, then address setup proves the toggle returned to 0.
        ctrl(8'h07, 8'h81);
        @(negedge pxclk);
        check_eq("reg1", 32'(regs[15:8]), 32'h07);
        check_eq("reg0", 32'(regs[7:0]), 32'h00);
        check_eq("reg_busy", 32'(cpu_busy), 32'd0);

        ctrl(8'h00, 8'h7F);
        data_wr(14'h3F00, 8'hAA); wait_idle();
        data_wr(14'h3F01, 8'h55); wait_idle();
        data_wr(14'h3F02, 8'h66); wait_idle();

        ctrl(8'hFF, 8'h7F);
        data_wr(14'h3FFF, 8'h11); wait_idle();
        data_wr(14'h0000, 8'h22); wait_idle();

        ctrl(8'h00, 8'h3F); wait_idle();
        rd(1'b0, 8'hAA, "rd_3f00"); wait_idle();
        rd(1'b0, 8'h55, "rd_3f01"); wait_idle();

        ctrl(8'h10, 8'h40);
        data_wr(14'h0010, 8'h5A); wait_idle();
        rd(1'b0, 8'h5A, "rd_after_wr"); wait_idle();

        // Starvation: video holds the bus, CPU write forced through after STARVE cycles.
        ctrl(8'h00, 8'h60);
        vid_addr = 14'h1234;
        vid_req  = 1'b1;
        data_wr(14'h2000, 8'h77);
        for (int k = 1; k <= STARVE + 1; k++) begin
            @(negedge pxclk);
            check_eq($sformatf("gnt_c%0d", k), 32'(vid_gnt), 32'(k <= STARVE));
            check_eq($sformatf("we_c%0d", k), 32'(vram_we), 32'(k == STARVE + 1));
            if (k == 1) check_eq("vid_addr_mux", 32'(vram_addr), 32'h1234);
        end
        @(negedge pxclk);
        check_eq("gnt_after", 32'(vid_gnt), 32'd1);
        check_eq("busy_after", 32'(cpu_busy), 32'd0);

        // Overrun: second data write while one is pending is dropped.
        ctrl(8'h00, 8'h61);
        data_wr(14'h2100, 8'h99);
        tick_wr(1'b0, 8'hEE);
        vid_req = 1'b0;
        wait_idle();
        rd(1'b1, 8'h20, "stat_ovr");
        rd(1'b1, 8'h00, "stat_clr");
        data_wr(14'h2101, 8'h44); wait_idle();

        // Interrupt enable and frame flag.
        ctrl(8'h20, 8'h81);
        @(negedge pxclk);
        check_eq("int_idle", 32'(int_n), 32'd1);
        vsync_tick = 1'b1;
        @(posedge pxclk); #1;
        vsync_tick = 1'b0;
        @(negedge pxclk);
        check_eq("int_set", 32'(int_n), 32'd0);
        rd(1'b1, 8'h80, "stat_f");
        check_eq("int_clr", 32'(int_n), 32'd1);
        rd(1'b1, 8'h00, "stat_f2");

        // vsync on the same cycle as a status read keeps F set.
        rd_q.push_back(8'h00);
        cpu_mode    = 1'b1;
        cpu_rd_tick = 1'b1;
        vsync_tick  = 1'b1;
        @(posedge pxclk); #1;
        cpu_rd_tick = 1'b0;
        vsync_tick  = 1'b0;
        @(negedge pxclk);
        check_eq("stat_vs_same", 32'(cpu_dout), 32'(rd_q.pop_front()));
        check_eq("int_vs_same", 32'(int_n), 32'd0);
        rd(1'b1, 8'h80, "stat_set_wins");

        // Reset while a write is pending: no write may ever appear.
        vid_req = 1'b1;
        ctrl(8'h00, 8'h62);
        tick_wr(1'b0, 8'hDD);
        @(negedge pxclk);
        check_eq("mid_busy", 32'(cpu_busy), 32'd1);
        @(posedge pxclk); #1;
        vid_req = 1'b0;
        reset   = 1'b1;
        @(negedge pxclk);
        check_eq("rst_cycle_we", 32'(vram_we), 32'd0);
        @(posedge pxclk); #1;
        reset = 1'b0;
        @(negedge pxclk);
        check_eq("post_rst_busy", 32'(cpu_busy), 32'd0);
        check_eq("post_rst_reg1", 32'(regs[15:8]), 32'h00);
        check_eq("post_rst_int", 32'(int_n), 32'd1);
        repeat (4) @(negedge pxclk);

        check_eq("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
